// File: rtl/test_ex3.sv
// test_ex3: iterative Collatz step counter for a 4-bit start value
module test_ex3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       xval,
  input  logic [3:0] x,
  output logic [4:0] y,
  output logic       yval
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t     state;
  logic [7:0] n;
  logic [4:0] cnt;
  // load on xval, iterate one Collatz step per clock, report step count when n<=1
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      n     <= 8'd0;
      cnt   <= 5'd0;
      y     <= 5'd0;
      yval  <= 1'b0;
    end else begin
      yval <= 1'b0;
      if (state == IDLE) begin
        if (xval) begin
          n     <= {4'b0, x};
          cnt   <= 5'd0;
          state <= RUN;
        end
      end else if (n <= 8'd1) begin
        y     <= cnt;
        yval  <= 1'b1;
        state <= IDLE;
      end else begin
        n   <= n[0] ? (n << 1) + n + 8'd1 : n >> 1;
        cnt <= cnt + 5'd1;
      end
    end
endmodule

// File: tb/tb_test_ex3.sv
// tb_test_ex3: directed self-checking bench for the Collatz step counter
module tb_test_ex3;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       xval = 1'b0;
  logic [3:0] x = 4'd0;
  logic [4:0] y;
  logic       yval;
  int total = 0;
  int bad = 0;
  int steps [16] = '{0, 0, 1, 7, 2, 5, 8, 16, 3, 19, 6, 14, 9, 9, 17, 17};

  test_ex3 dut (.clk(clk), .rst(rst), .xval(xval), .x(x), .y(y), .yval(yval));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // start with value v, expect completion S+1 edges after the sampling edge;
  // poke>0 drives a stray xval with x=2 for one cycle at that RUN cycle
  task automatic run(input int v, input int s, input int poke);
    xval = 1'b1;
    x = 4'(v);
    step();
    xval = 1'b0;
    chk($sformatf("yval_e0_x%0d", v), int'(yval), 0);
    for (int k = 1; k <= s + 1; k++) begin
      if (k == poke) begin
        xval = 1'b1;
        x = 4'd2;
      end
      step();
      if (k == poke) xval = 1'b0;
      chk($sformatf("yval_x%0d_k%0d", v, k), int'(yval), (k == s + 1) ? 1 : 0);
    end
    chk($sformatf("y_x%0d", v), int'(y), s);
  endtask

  task automatic quiet(input int cycles, input int ey, input string tag);
    for (int k = 0; k < cycles; k++) begin
      step();
      chk($sformatf("%s_yval_%0d", tag, k), int'(yval), 0);
      chk($sformatf("%s_y_%0d", tag, k), int'(y), ey);
    end
  endtask

  initial begin
    xval = 1'b1;
    x = 4'd5;
    #1;
    quiet(2, 0, "reset_hold");
    rst = 1'b1;
    xval = 1'b0;
    quiet(5, 0, "post_reset");
    run(2, 1, 0);
    quiet(25, 1, "hold2");
    run(3, 7, 0);
    quiet(25, 7, "hold3");
    for (int v = 0; v < 16; v++) run(v, steps[v], 0);
    step();
    chk("sweep_end_yval", int'(yval), 0);
    run(9, 19, 5);
    step();
    chk("poke_after_yval", int'(yval), 0);
    chk("poke_after_y", int'(y), 19);
    xval = 1'b1;
    x = 4'd15;
    step();
    xval = 1'b0;
    repeat (6) step();
    rst = 1'b0;
    #1;
    chk("abort_async_y", int'(y), 0);
    chk("abort_async_yval", int'(yval), 0);
    step();
    rst = 1'b1;
    quiet(25, 0, "abort");
    run(4, 2, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
